// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a registered one-hot grant, a binary grant index and a maximum hold time.
// A released grant is always followed by one idle cycle, and the search pointer then moves past the last owner.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ptr;
    logic [1:0]      w_ptr_nxt;
    logic [CW-1:0]   r_hold_cnt;
    logic [CW-1:0]   w_hold_nxt;
    logic [3:0]      r_grant;
    logic [3:0]      w_grant_nxt;
    logic [1:0]      r_grant_id;
    logic [1:0]      w_grant_id_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;

    logic [2:0]      w_win;
    logic            w_rel_done;
    logic            w_rel_drop;
    logic            w_rel_hold;

    // Returns {found, index}; walking offsets downward lets the lowest offset from p win.
    function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            c = p + 2'(k);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    assign w_win      = pick_winner(req, r_ptr);
    assign w_rel_done = done;
    assign w_rel_drop = ~req[r_grant_id];
    assign w_rel_hold = (r_hold_cnt == HOLD_LIMIT);

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_hold_nxt     = r_hold_cnt;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win[2]) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_nxt    = 4'b0001 << w_win[1:0];
                    w_grant_id_nxt = w_win[1:0];
                    w_busy_nxt     = 1'b1;
                    w_hold_nxt     = CW'(1);
                end
            end
            S_GRANT: begin
                if (w_rel_done || w_rel_drop || w_rel_hold) begin
                    w_state_nxt    = S_IDLE;
                    w_grant_nxt    = 4'b0000;
                    w_grant_id_nxt = 2'b00;
                    w_busy_nxt     = 1'b0;
                    w_ptr_nxt      = r_grant_id + 2'd1;
                    w_hold_nxt     = '0;
                    // Flag the hold limit only when it is the sole reason for release.
                    w_timeout_nxt  = w_rel_hold && !w_rel_done && !w_rel_drop;
                end else begin
                    w_hold_nxt = r_hold_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'b00;
            r_hold_cnt <= '0;
            r_grant    <= 4'b0000;
            r_grant_id <= 2'b00;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign timeout  = r_timeout;

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Round-robin arbiter that shares one single-consumer resource (e.g. a 4-to-2 encoder-indexed datapath or bus slot) among four requesters. It resolves a 4-bit request vector into a registered one-hot grant plus its 2-bit binary index, holds the grant until the owner releases it, and enforces a maximum hold time. It sits between the requester ports and the shared resource, whose select input is driven by `grant_id`.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one requester may hold the grant; legal range 2..255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request lines; bit i = requester i; level-sensitive.
- `done`  input  1  single-cycle release pulse from the resource for the current owner.
- `grant`  output  4  registered one-hot grant; all-zero when idle.
- `grant_id`  output  2  binary index of the granted requester: 0001→00, 0010→01, 0100→10, 1000→11; 00 when idle.
- `busy`  output  1  high while any grant is active.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Two-state FSM: IDLE, GRANT. Internal state: 2-bit round-robin pointer `ptr`, hold counter `hold_cnt` of width $clog2(MAX_HOLD+1).
- Reset: state=IDLE, `ptr`=0, `hold_cnt`=0, `grant`=0000, `grant_id`=00, `busy`=0, `timeout`=0. Reset overrides all other inputs, including mid-grant; the grant drops at that edge.
- IDLE:
  - `req`=0000: stay in IDLE.
  - Otherwise: the winner is the first set bit of `req` searching `ptr`, `ptr`+1, … modulo 4. Next state is GRANT. Load `grant` with the winner's one-hot, `grant_id` with its index, `busy`=1, `hold_cnt`=1.
- GRANT: release when any of the following holds:
  - (a) `done`=1,
  - (b) `req[grant_id]`=0,
  - (c) `hold_cnt`==MAX_HOLD.
- On release:
  - Next state is IDLE. Clear `grant`/`grant_id`/`busy`.
  - `ptr` ← `grant_id`+1 mod 4 (wraps 3→0).
  - `hold_cnt` ← 0.
- If there is no release, `hold_cnt` increments by 1.
- `timeout`=1 for exactly one cycle (registered, coincident with the IDLE cycle) only when release is due solely to (c). If (a) or (b) is true in the same cycle, `timeout` stays 0.
- Requests that change while in GRANT do not affect the owner. Only the owner's bit is examined.
- `grant` is always one-hot or zero. `grant_id` is always consistent with `grant`. Both are driven from flops only.

## Timing
- Grant latency: `req` sampled at edge N in IDLE → `grant` valid after edge N (visible in cycle N+1).
- Minimum hold: 1 cycle. Maximum hold: MAX_HOLD cycles of `busy`=1.
- A release condition present in cycle N ends `busy` after edge N.
- Exactly one IDLE cycle separates consecutive grants, even with continuous requests. This gives a sustained rate of one grant per (hold+1) cycles.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,…. Each requester waits at most 3 grants.
- `done` asserted in IDLE is ignored.

## Test plan
- Reset/idle: assert `rst` 2 cycles with `req`=1111 → `grant`=0000, `grant_id`=00, `busy`=0, `timeout`=0 throughout. Release `rst` → `grant`=0001 one cycle later.
- Single requester: `req`=0100 held, `done` pulsed on the 3rd busy cycle → `grant`=0100 and `grant_id`=10 for 3 cycles, then one IDLE cycle, then `grant`=0100 again (sole requester wraps back).
- Rotation: `req`=1111 continuous, `done` pulsed after each 2-cycle hold → `grant_id` sequence 00,01,10,11,00 with one idle cycle between each grant.
- Pointer wrap/skip: after grant to requester 2, `req`=0011 → next grant `grant_id`=00 (search order 3,0,1,2 with 3 absent).
- Timeout (MAX_HOLD=4): `req`=0010 held, no `done` → `busy` high exactly 4 cycles, `timeout`=1 for one cycle as `busy` falls. Repeat with `done`=1 on cycle 4 → `timeout` stays 0.
- Mid-operation events: owner drops `req` in busy cycle 2 → release after that edge with no `timeout`. Assert `rst` during GRANT → all outputs 0 next cycle and `ptr` returns to 0, so `req`=1111 then yields `grant_id`=00.
